// File: rtl/encoder_ctrl_if.sv
// encoder_ctrl_if: AXI-Stream style bundle (data, rate tag, valid/ready, last) used on both
// sides of encoder_ctrl.
interface encoder_ctrl_if #(
    parameter int WIDTH = 24
);
    logic [WIDTH-1:0] tdata;
    logic [3:0]       tuser;
    logic             tvalid;
    logic             tready;
    logic             tlast;

    modport master (output tdata, tuser, tvalid, tlast, input tready);
    modport slave  (input tdata, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/encoder_ctrl.sv
// encoder_ctrl: emits a SIGNAL word, clears the encoder, then forwards cfg_words DATA words.
// Optional upstream tlast length checking: define ENCODER_CTRL_LEN_CHECK_EN.
module encoder_ctrl #(
    parameter int WIDTH = 24
) (
    input  logic           aclk,
    input  logic           aresetn,
    input  logic [3:0]     cfg_rate,
    input  logic [11:0]    cfg_length,
    input  logic [11:0]    cfg_words,
    input  logic           cfg_valid,
    output logic           cfg_ready,
    encoder_ctrl_if.slave  s_axis,
    encoder_ctrl_if.master m_axis,
    output logic           enc_clear,
    output logic           done,
    output logic           err
);
    localparam logic [3:0] RATE_6M = 4'hD;

    typedef enum logic [1:0] {IDLE, SIG, CLR, DATA} state_t;

    state_t           state;
    logic [3:0]       rate_q;
    logic [11:0]      words_q;
    logic [11:0]      cnt;
    logic [WIDTH-1:0] tdata_q;
    logic [3:0]       tuser_q;
    logic             tvalid_q;
    logic             tlast_q;

    logic [16:0]      sig_low;
    logic [11:0]      cnt_next;
    logic             last_word;
    logic             s_ready;
    logic             s_fire;
    logic             m_fire;

    assign sig_low   = {cfg_length, 1'b0, cfg_rate};
    assign cnt_next  = cnt + 12'd1;
    assign last_word = (cnt_next == words_q);

    // NOTE: ready is combinational on m_axis.tready so the single output register can be
    // refilled in the same cycle it drains; cnt == words_q closes the input after the last word.
    assign s_ready = (state == DATA) && (cnt != words_q) && (!tvalid_q || m_axis.tready);
    assign s_fire  = s_ready && s_axis.tvalid;
    assign m_fire  = tvalid_q && m_axis.tready;

    assign s_axis.tready = s_ready;
    assign m_axis.tdata  = tdata_q;
    assign m_axis.tuser  = tuser_q;
    assign m_axis.tvalid = tvalid_q;
    assign m_axis.tlast  = tlast_q;

    // NOTE: every register here uses non-blocking assignment so all of them sample pre-edge values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= IDLE;
            cfg_ready <= 1'b0;
            rate_q    <= '0;
            words_q   <= '0;
            cnt       <= '0;
            tdata_q   <= '0;
            tuser_q   <= '0;
            tvalid_q  <= 1'b0;
            tlast_q   <= 1'b0;
            enc_clear <= 1'b0;
            done      <= 1'b0;
        end else begin
            enc_clear <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    cfg_ready <= 1'b1;
                    if (cfg_valid && cfg_ready) begin
                        rate_q    <= cfg_rate;
                        words_q   <= cfg_words;
                        cnt       <= '0;
                        tdata_q   <= {{(WIDTH-18){1'b0}}, ^sig_low, sig_low};
                        tuser_q   <= RATE_6M;
                        tlast_q   <= 1'b1;
                        tvalid_q  <= 1'b1;
                        cfg_ready <= 1'b0;
                        state     <= SIG;
                    end
                end
                SIG: begin
                    if (m_fire) begin
                        tvalid_q <= 1'b0;
                        tlast_q  <= 1'b0;
                        if (words_q == 12'd0) begin
                            done      <= 1'b1;
                            cfg_ready <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            enc_clear <= 1'b1;
                            state     <= CLR;
                        end
                    end
                end
                CLR: state <= DATA;
                DATA: begin
                    if (s_fire) begin
                        tdata_q  <= s_axis.tdata;
                        tuser_q  <= rate_q;
                        tlast_q  <= last_word;
                        tvalid_q <= 1'b1;
                        cnt      <= cnt_next;
                    end else if (m_fire) begin
                        tvalid_q <= 1'b0;
                        if (tlast_q) begin
                            tlast_q   <= 1'b0;
                            done      <= 1'b1;
                            cfg_ready <= 1'b1;
                            state     <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ENCODER_CTRL_LEN_CHECK_EN
    // Sticky: a tlast disagreement is flagged but forwarding keeps following the count.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            err <= 1'b0;
        end else if (s_fire && (s_axis.tlast != last_word)) begin
            err <= 1'b1;
        end
    end
`else
    assign err = 1'b0;
`endif
endmodule

// File: tb/tb_encoder_ctrl.sv
// tb_encoder_ctrl: directed self-checking bench for encoder_ctrl (SIGNAL framing, streaming,
// stalls, mid-frame reset, held config requests, optional length check).
module tb_encoder_ctrl;
    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [3:0]  cfg_rate = '0;
    logic [11:0] cfg_length = '0;
    logic [11:0] cfg_words = '0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic        enc_clear;
    logic        done;
    logic        err;

    encoder_ctrl_if #(.WIDTH(24)) s_if ();
    encoder_ctrl_if #(.WIDTH(24)) m_if ();

    encoder_ctrl #(.WIDTH(24)) dut (
        .aclk       (aclk),
        .aresetn    (aresetn),
        .cfg_rate   (cfg_rate),
        .cfg_length (cfg_length),
        .cfg_words  (cfg_words),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .s_axis     (s_if),
        .m_axis     (m_if),
        .enc_clear  (enc_clear),
        .done       (done),
        .err        (err)
    );

    always #5 aclk = ~aclk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [23:0] q_data[$];
    logic [3:0]  q_user[$];
    logic        q_last[$];
    int          q_cyc[$];
    int          clr_cnt;
    int          done_cnt;
    int          src_idx;
    int          cfg_rdy_bad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tvalid"}, m_if.tvalid, 0);
        check({tag, "_tlast"}, m_if.tlast, 0);
        check({tag, "_tdata"}, m_if.tdata, 0);
        check({tag, "_tuser"}, m_if.tuser, 0);
        check({tag, "_s_tready"}, s_if.tready, 0);
        check({tag, "_enc_clear"}, enc_clear, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_cfg_ready"}, cfg_ready, 0);
    endtask

    task automatic request(input logic [3:0] rate, input logic [11:0] len,
                           input logic [11:0] words, input bit hold);
        bit seen = 1'b0;
        @(posedge aclk); #1;
        cfg_rate = rate; cfg_length = len; cfg_words = words; cfg_valid = 1'b1;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge aclk);
            if (cfg_ready) seen = 1'b1;
        end
        check("cfg_accepted", seen, 1);
        @(posedge aclk); #1;
        if (!hold) cfg_valid = 1'b0;
    endtask

    task automatic drive(input int words, input bit stall, input int tlast_at,
                         input logic [23:0] base);
        s_if.tvalid = (src_idx < words);
        s_if.tdata  = base + 24'(src_idx);
        s_if.tlast  = (src_idx + 1 == tlast_at);
        m_if.tready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
    endtask

    // Runs one frame from the cycle after config acceptance until done (or abort via reset).
    task automatic stream(input int words, input bit stall, input int tlast_at,
                          input int abort_at, input logic [23:0] base);
        bit          fin = 1'b0;
        bit          pend = 1'b0;
        logic [23:0] h_data;
        logic [3:0]  h_user;
        logic        h_last;
        q_data.delete(); q_user.delete(); q_last.delete(); q_cyc.delete();
        clr_cnt = 0; done_cnt = 0; src_idx = 0;
        drive(words, stall, tlast_at, base);
        for (int c = 0; c < 3000 && !fin; c++) begin
            @(negedge aclk);
            if (pend) begin
                check("stall_tvalid", m_if.tvalid, 1);
                check("stall_tdata", m_if.tdata, h_data);
                check("stall_tuser", m_if.tuser, h_user);
                check("stall_tlast", m_if.tlast, h_last);
                pend = 1'b0;
            end
            if (m_if.tvalid && !m_if.tready) begin
                pend = 1'b1; h_data = m_if.tdata; h_user = m_if.tuser; h_last = m_if.tlast;
            end
            if (m_if.tvalid && m_if.tready) begin
                q_data.push_back(m_if.tdata); q_user.push_back(m_if.tuser);
                q_last.push_back(m_if.tlast); q_cyc.push_back(c);
            end
            if (s_if.tvalid && s_if.tready) src_idx++;
            if (enc_clear) clr_cnt++;
            if (cfg_ready && !done) cfg_rdy_bad++;
            if (done) begin
                done_cnt++;
                fin = 1'b1;
            end
            if (abort_at != 0 && q_data.size() == abort_at + 1 && m_if.tvalid) begin
                aresetn = 1'b0;
                fin = 1'b1;
            end else if (!fin) begin
                @(posedge aclk); #1;
                drive(words, stall, tlast_at, base);
            end
        end
        check("frame_finished", fin, 1);
    endtask

    task automatic verify(input logic [23:0] sig, input logic [3:0] rate, input int words,
                          input logic [23:0] base, input int exp_clr);
        check("beat_count", q_data.size(), words + 1);
        if (q_data.size() > 0) begin
            check("sig_tdata", q_data[0], sig);
            check("sig_tuser", q_user[0], 4'hD);
            check("sig_tlast", q_last[0], 1);
        end
        for (int i = 1; i < q_data.size(); i++) begin
            check("data_tdata", q_data[i], base + 24'(i - 1));
            check("data_tuser", q_user[i], rate);
            check("data_tlast", q_last[i], (i == words));
        end
        check("src_consumed", src_idx, words);
        check("enc_clear_cycles", clr_cnt, exp_clr);
        check("done_pulses", done_cnt, 1);
    endtask

    initial begin
        s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tuser = '0; s_if.tlast = 1'b0;
        m_if.tready = 1'b0;

        // Reset state, then cfg_ready rises one cycle after release.
        repeat (3) @(negedge aclk);
        check_reset_outputs("reset");
        aresetn = 1'b1;
        #1 check("cfg_ready_pre_edge", cfg_ready, 0);
        @(posedge aclk); #1;
        check("cfg_ready_post_edge", cfg_ready, 1);
        check("idle_s_tready", s_if.tready, 0);

        // 6M, length 100, no DATA words: SIGNAL only, no clear.
        request(4'hD, 12'd100, 12'd0, 0);
        stream(0, 0, 0, 0, 24'h0);
        verify(24'h000C8D, 4'hD, 0, 24'h0, 0);

        // 9M, length 200, 10 words back to back.
        request(4'hF, 12'd200, 12'd10, 0);
        stream(10, 0, 10, 0, 24'hA50000);
        verify(24'h02190F, 4'hF, 10, 24'hA50000, 1);
        if (q_cyc.size() == 11) check("back_to_back_span", q_cyc[10] - q_cyc[1], 9);

        // Same frame under random downstream stalls.
        request(4'hF, 12'd200, 12'd10, 0);
        stream(10, 1, 10, 0, 24'h3C0100);
        verify(24'h02190F, 4'hF, 10, 24'h3C0100, 1);

        // Reset while DATA word 4 is held on the output.
        request(4'hF, 12'd200, 12'd10, 0);
        stream(10, 0, 10, 4, 24'h112200);
        #1 check_reset_outputs("abort");
        s_if.tvalid = 1'b0;
        @(negedge aclk);
        aresetn = 1'b1;
        #1 check("abort_cfg_ready_pre", cfg_ready, 0);
        @(posedge aclk); #1;
        check("abort_cfg_ready_post", cfg_ready, 1);
        request(4'h5, 12'd50, 12'd3, 0);
        stream(3, 0, 3, 0, 24'h7F0000);
        verify(24'h020645, 4'h5, 3, 24'h7F0000, 1);

        // cfg_valid held through a frame: the second request waits for done.
        cfg_rdy_bad = 0;
        request(4'hB, 12'd1, 12'd2, 1);
        stream(2, 0, 2, 0, 24'h000010);
        verify(24'h00002B, 4'hB, 2, 24'h000010, 1);
        check("held_cfg_ready_low", cfg_rdy_bad, 0);
        check("held_cfg_ready_at_done", cfg_ready, 1);
        @(posedge aclk); #1;
        cfg_valid = 1'b0;
        check("held_second_sig_valid", m_if.tvalid, 1);
        check("held_second_sig_data", m_if.tdata, 24'h00002B);
        stream(2, 0, 2, 0, 24'h000020);
        verify(24'h00002B, 4'hB, 2, 24'h000020, 1);

        // Upstream tlast on word 3 of a 5-word frame.
        request(4'hD, 12'd100, 12'd5, 0);
        stream(5, 0, 3, 0, 24'h550000);
        verify(24'h000C8D, 4'hD, 5, 24'h550000, 1);
`ifdef ENCODER_CTRL_LEN_CHECK_EN
        check("len_err_set", err, 1);
        request(4'hD, 12'd100, 12'd0, 0);
        stream(0, 0, 0, 0, 24'h0);
        check("len_err_sticky", err, 1);
`else
        check("len_err_tied_low", err, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
